// File: rtl/serial_pattern_tx_pkg.sv
// Shared encodings and parameter limits for the serial pattern transmitter.
package serial_pattern_tx_pkg;

    // A:B encoding of the two JK state flops; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic IDLE_LVL_DEF = 1'b0;
    localparam int   WIDTH_MIN    = 2;
    localparam int   WIDTH_MAX    = 16;

    function automatic bit width_ok(int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Frame request / serial output bundle between a stimulus owner and the transmitter.
interface serial_pattern_tx_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             x_out;
    logic             busy;
    logic             done;

    modport master (output start, output data_in, input x_out, input busy, input done);
    modport slave  (input start, input data_in, output x_out, output busy, output done);
endinterface

// File: rtl/serial_pattern_tx_jk.sv
// JK flip-flop built on an async active-low reset D flop.
module jk_flop (
    input  logic Clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);
    logic q_q, q_d;

    always_comb q_d = (j & ~q_q) | (~k & q_q);

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) q_q <= 1'b0;
        else      q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-stream transmitter: loads a word on start and shifts it out one bit per Clk.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_LVL  = IDLE_LVL_DEF
) (
    input  logic Clk,
    input  logic rst,
    serial_pattern_tx_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    if (!width_ok(WIDTH)) begin : g_width_chk
        $error("serial_pattern_tx: WIDTH out of range 2..16");
    end

    logic             a_q, b_q;
    logic             ja, ka, jb, kb;
    state_e           state;
    logic             last;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_q, cnt_j, cnt_k;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             out_bit;

    always_comb begin
        state = state_e'({a_q, b_q});
        last  = (cnt_q == CNT_W'(WIDTH - 1));
        ja    = b_q & last;
        ka    = 1'b1;
        jb    = ~a_q & ~b_q & bus.start;
        // A is only set in DONE (B already 0) or the illegal 11, where this clears B.
        kb    = last | a_q;
    end

    // Synchronous up-counter: toggle when all lower bits are set; J=0,K=1 clears.
    always_comb begin
        logic low;
        low    = 1'b1;
        cnt_en = (state == ST_SHIFT) & ~last;
        cnt_j  = '0;
        cnt_k  = '0;
        for (int i = 0; i < CNT_W; i++) begin
            cnt_j[i] = cnt_en & low;
            cnt_k[i] = ~cnt_en | low;
            low      = low & cnt_q[i];
        end
    end

    always_comb begin
        sr_d = sr_q;
        case (state)
            ST_IDLE:  if (bus.start) sr_d = bus.data_in;
            ST_SHIFT: sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
            default:  ;
        endcase
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else      sr_q <= sr_d;
    end

    jk_flop u_st_a (.Clk(Clk), .rst(rst), .j(ja), .k(ka), .q(a_q));
    jk_flop u_st_b (.Clk(Clk), .rst(rst), .j(jb), .k(kb), .q(b_q));

    for (genvar i = 0; i < CNT_W; i++) begin : g_cnt
        jk_flop u_cnt (.Clk(Clk), .rst(rst), .j(cnt_j[i]), .k(cnt_k[i]), .q(cnt_q[i]));
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    always_comb begin
        out_bit   = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
        bus.x_out = (state == ST_SHIFT) ? out_bit : IDLE_LVL;
        bus.busy  = (state == ST_SHIFT) || (state == ST_DONE);
        bus.done  = (state == ST_DONE);
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: one MSB-first and one LSB-first instance.
module tb_serial_pattern_tx;
    logic Clk = 1'b0;
    logic rst = 1'b0;
    always #5 Clk = ~Clk;

    serial_pattern_tx_if #(.WIDTH(8)) im ();
    serial_pattern_tx_if #(.WIDTH(8)) il ();

    serial_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u_m (.Clk(Clk), .rst(rst), .bus(im));
    serial_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_l (.Clk(Clk), .rst(rst), .bus(il));

    int n_chk = 0, n_pass = 0, cyc = 0;
    int nb[2], done_n[2], dprev[2], dlast[2];
    logic [7:0] word[2];
    logic [7:0] exp_m[$], exp_l[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic xo(int s); return s != 0 ? il.x_out : im.x_out; endfunction
    function automatic logic bz(int s); return s != 0 ? il.busy  : im.busy;  endfunction
    function automatic logic dn(int s); return s != 0 ? il.done  : im.done;  endfunction

    task automatic drv(int s, logic st, logic [7:0] d);
        if (s != 0) begin il.start = st; il.data_in = d; end
        else        begin im.start = st; im.data_in = d; end
    endtask

    task automatic push(int s, logic [7:0] d);
        if (s != 0) exp_l.push_back(d);
        else        exp_m.push_back(d);
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: collect bits while shifting, reassemble and score on the done pulse.
    always @(negedge Clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst) nb[s] = 0;
            else begin
                if (bz(s) && !dn(s)) begin
                    word[s] = (s != 0) ? {xo(s), word[s][7:1]} : {word[s][6:0], xo(s)};
                    nb[s]++;
                end
                if (dn(s)) begin
                    int qs;
                    logic [7:0] e;
                    chk("nbits", nb[s], 8);
                    nb[s] = 0;
                    done_n[s]++;
                    dprev[s] = dlast[s];
                    dlast[s] = cyc;
                    qs = (s != 0) ? exp_l.size() : exp_m.size();
                    chk("sb_nonempty", qs > 0, 1);
                    if (qs > 0) begin
                        if (s != 0) e = exp_l.pop_front();
                        else        e = exp_m.pop_front();
                        chk("sb_word", word[s], e);
                    end
                end
            end
        end
    end

    // Called at #1 after the accepting edge; optionally pulses start at bit inj.
    task automatic frame_check(int s, logic [7:0] d, int inj);
        for (int k = 0; k < 8; k++) begin
            chk("bit", xo(s), (s != 0) ? d[k] : d[7-k]);
            chk("busy_shift", bz(s), 1);
            chk("done_shift", dn(s), 0);
            if (k == inj)     drv(s, 1'b0, 8'hFF);
            if (k + 1 == inj) drv(s, 1'b1, 8'hFF);
            @(posedge Clk); #1;
        end
        chk("done_hi", dn(s), 1);
        chk("busy_done", bz(s), 1);
        chk("x_done", xo(s), 0);
        @(posedge Clk); #1;
        chk("done_lo", dn(s), 0);
        chk("busy_lo", bz(s), 0);
    endtask

    task automatic send(int s, logic [7:0] d, int inj);
        drv(s, 1'b1, d);
        push(s, d);
        @(posedge Clk); #1;
        drv(s, 1'b0, d);
        frame_check(s, d, inj);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn0, base;
        for (int s = 0; s < 2; s++) begin nb[s] = 0; done_n[s] = 0; dprev[s] = 0; dlast[s] = 0; word[s] = '0; end
        drv(0, 1'b1, 8'h3C);
        drv(1, 1'b0, 8'h00);
        // Reset held with start high
        #2;
        chk("rst_x_m", im.x_out, 0); chk("rst_busy_m", im.busy, 0); chk("rst_done_m", im.done, 0);
        chk("rst_x_l", il.x_out, 0); chk("rst_busy_l", il.busy, 0);
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_hold_busy", im.busy, 0);
        push(0, 8'h3C);
        rst = 1'b1;
        #1;
        chk("rel_busy", im.busy, 0);
        @(posedge Clk); #1;
        drv(0, 1'b0, 8'h3C);
        frame_check(0, 8'h3C, -1);

        // MSB-first and LSB-first frames
        send(0, 8'hA5, -1);
        send(1, 8'hA5, -1);
        send(1, 8'h01, -1);

        // start during a frame is ignored
        send(0, 8'h0F, 3);
        repeat (3) @(posedge Clk);
        #1;
        chk("no_second_frame", im.busy, 0);

        // Async reset mid-frame
        drv(0, 1'b1, 8'hC3);
        push(0, 8'hC3);
        @(posedge Clk); #1;
        drv(0, 1'b0, 8'hC3);
        for (int k = 0; k < 4; k++) begin
            chk("abort_bit", im.x_out, (8'hC3 >> (7 - k)) & 8'h01);
            @(posedge Clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        chk("abort_x", im.x_out, 0); chk("abort_busy", im.busy, 0); chk("abort_done", im.done, 0);
        exp_m.delete();
        dn0 = done_n[0];
        repeat (2) @(posedge Clk);
        #1 rst = 1'b1;
        repeat (12) @(posedge Clk);
        #1;
        chk("abort_nodone", done_n[0], dn0);
        send(0, 8'h5A, -1);

        // start held high: back-to-back frames
        base = done_n[0];
        drv(0, 1'b1, 8'h81);
        push(0, 8'h81);
        push(0, 8'h7E);
        @(posedge Clk); #1;
        drv(0, 1'b1, 8'h7E);
        repeat (10) @(posedge Clk);
        #1 drv(0, 1'b0, 8'h7E);
        repeat (11) @(posedge Clk);
        #1;
        chk("b2b_count", done_n[0] - base, 2);
        chk("b2b_spacing", dlast[0] - dprev[0], 10);
        chk("b2b_idle", im.busy, 0);

        chk("sb_drain_m", exp_m.size(), 0);
        chk("sb_drain_l", exp_l.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
